// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, fetch-sequencer states and branch alignment for the core.
package cpu_pkg;
  localparam int PC_W = 10;
  localparam int BR_ALIGN = 3;
  typedef enum logic [1:0] {PC_IDLE, PC_RUN, PC_HALTED} pc_state_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (clr) count <= '0;
    else if (en && count != '1) count <= count + W'(1);
endmodule

// File: rtl/program_counter.sv
// program_counter: fetch address sequencer with run/halt FSM and retired-instruction count.
module program_counter
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  start_addr,
  input  logic             branch,
  input  logic [PC_W-1:0]  target,
  input  logic             halt,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] retired
);
  pc_state_e state, next_state;
  logic [PC_W-1:0] next_pc;
  logic accept;
  assign accept = start && state != PC_RUN;
  assign running = state == PC_RUN;
  assign done = state == PC_HALTED;
  // halt outranks branch: the HALT instruction's own address stays on pc
  always_comb begin
    next_state = state;
    next_pc = pc;
    if (accept) begin
      next_state = PC_RUN;
      next_pc = start_addr;
    end else if (running) begin
      next_state = halt ? PC_HALTED : PC_RUN;
      next_pc = halt ? pc : branch ? target : pc + PC_W'(1);
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= PC_IDLE;
      pc <= '0;
    end else begin
      state <= next_state;
      pc <= next_pc;
    end
  sat_counter #(.W(CNT_W)) u_retired (
    .clk(clk),
    .reset(reset),
    .clr(accept),
    .en(running),
    .count(retired)
  );
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed vector table plus hand sequences for reset, saturation and ignored start.
module tb_program_counter;
  import cpu_pkg::*;
  localparam int CNT_W = 4;
  logic clk = 0, reset = 0, start = 0, branch = 0, halt = 0;
  logic [PC_W-1:0] start_addr = '0, target = '0, pc;
  logic running, done;
  logic [CNT_W-1:0] retired;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  program_counter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .branch(branch), .target(target), .halt(halt),
    .pc(pc), .running(running), .done(done), .retired(retired)
  );
  typedef struct {
    logic s; logic [9:0] sa; logic b; logic [9:0] t; logic h;
    logic [9:0] e_pc; logic e_run; logic e_done; logic [3:0] e_ret;
  } vec_t;
  vec_t v[17];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic chk_all(input string n, input logic [9:0] p, input logic r, input logic d, input logic [3:0] c);
    chk({n, "_pc"}, 32'(pc), 32'(p));
    chk({n, "_running"}, 32'(running), 32'(r));
    chk({n, "_done"}, 32'(done), 32'(d));
    chk({n, "_retired"}, 32'(retired), 32'(c));
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic s, input logic [9:0] sa, input logic b, input logic [9:0] t, input logic h);
    start = s; start_addr = sa; branch = b; target = t; halt = h;
    tick();
    start = 0; branch = 0; halt = 0;
  endtask
  initial begin
    v[0]  = '{1, 10'h010, 0, 10'h000, 0, 10'h010, 1, 0, 4'd0};
    v[1]  = '{0, 10'h000, 0, 10'h000, 0, 10'h011, 1, 0, 4'd1};
    v[2]  = '{0, 10'h000, 0, 10'h000, 0, 10'h012, 1, 0, 4'd2};
    v[3]  = '{0, 10'h000, 0, 10'h000, 0, 10'h013, 1, 0, 4'd3};
    v[4]  = '{0, 10'h000, 0, 10'h000, 0, 10'h014, 1, 0, 4'd4};
    v[5]  = '{0, 10'h000, 1, 10'h020, 0, 10'h020, 1, 0, 4'd5};
    v[6]  = '{0, 10'h000, 1, 10'h0A8, 0, 10'h0A8, 1, 0, 4'd6};
    v[7]  = '{0, 10'h000, 0, 10'h000, 0, 10'h0A9, 1, 0, 4'd7};
    v[8]  = '{0, 10'h000, 1, 10'h030, 0, 10'h030, 1, 0, 4'd8};
    v[9]  = '{0, 10'h000, 1, 10'h100, 1, 10'h030, 0, 1, 4'd9};
    v[10] = '{0, 10'h000, 0, 10'h000, 0, 10'h030, 0, 1, 4'd9};
    v[11] = '{0, 10'h000, 1, 10'h200, 1, 10'h030, 0, 1, 4'd9};
    v[12] = '{1, 10'h3FE, 0, 10'h000, 1, 10'h3FE, 1, 0, 4'd0};
    v[13] = '{0, 10'h000, 0, 10'h000, 0, 10'h3FF, 1, 0, 4'd1};
    v[14] = '{0, 10'h000, 0, 10'h000, 0, 10'h000, 1, 0, 4'd2};
    v[15] = '{0, 10'h000, 0, 10'h000, 1, 10'h000, 0, 1, 4'd3};
    v[16] = '{1, 10'h008, 0, 10'h000, 0, 10'h008, 1, 0, 4'd0};
    #1 chk_all("reset", 10'h000, 0, 0, 4'd0);
    tick();
    reset = 1;
    drive(0, 10'h000, 1, 10'h080, 1);
    chk_all("idle_ignores_branch_halt", 10'h000, 0, 0, 4'd0);
    for (int i = 0; i < 17; i++) begin
      drive(v[i].s, v[i].sa, v[i].b, v[i].t, v[i].h);
      chk_all($sformatf("vec%0d", i), v[i].e_pc, v[i].e_run, v[i].e_done, v[i].e_ret);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) chk("sat_reach15", 32'(retired), 32'd15);
    end
    chk_all("sat_hold", 10'h01C, 1, 0, 4'd15);
    drive(1, 10'h3C0, 0, 10'h000, 0);
    chk_all("start_in_run_ignored", 10'h01D, 1, 0, 4'd15);
    drive(0, 10'h000, 0, 10'h000, 1);
    drive(1, 10'h040, 0, 10'h000, 0);
    for (int i = 0; i < 5; i++) tick();
    chk_all("pre_reset", 10'h045, 1, 0, 4'd5);
    #2 reset = 0;
    #1 chk_all("async_reset", 10'h000, 0, 0, 4'd0);
    tick();
    #2 reset = 1;
    tick();
    tick();
    chk_all("post_reset_idle", 10'h000, 0, 0, 4'd0);
    drive(1, 10'h050, 0, 10'h000, 0);
    chk_all("restart_after_reset", 10'h050, 1, 0, 4'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/program_counter.md
# program_counter

Program counter and fetch sequencer for the single-cycle core. It sits directly downstream of the branch unit. Each cycle it consumes the branch decision and the 10-bit branch target, and it drives the instruction-memory address. It also owns the run/halt state machine, which controls program start and completion. A saturating retired-instruction counter is included for test-bench cycle accounting.

## Interface
- PC_W, 10, width of the program counter and instruction address.
- CNT_W, 16, width of the retired-instruction counter.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins execution at `start_addr`.
- start_addr  input  PC_W  first instruction address; sampled only when `start` is accepted.
- branch  input  1  taken-branch decision from the branch unit for the current instruction.
- target  input  PC_W  absolute branch target from the branch unit (8-aligned).
- halt  input  1  the current instruction decodes as HALT.
- pc  output  PC_W  instruction-memory address of the current instruction.
- running  output  1  high while in RUN; instructions retire only when high.
- done  output  1  high while in HALTED; ack to the test harness.
- retired  output  CNT_W  number of instructions retired since the last accepted `start`.

## Operation
- The state machine has three states:
  - IDLE (reset state): no retirement, pc holds.
  - RUN: one instruction retires per cycle.
  - HALTED: pc frozen, `done`=1.
- Transitions:
  - IDLE --start--> RUN
  - RUN --halt--> HALTED
  - HALTED --start--> RUN
- `start` is accepted in IDLE or HALTED. On acceptance: pc <= start_addr, retired <= 0.
- `start` is ignored in RUN.
- Next-pc in RUN, highest priority first:
  - halt: pc holds; the HALT instruction's own address remains on `pc`.
  - branch: pc <= target.
  - otherwise: pc <= pc+1.
- pc+1 is modulo 2^PC_W; 10'h3FF increments to 10'h000 with no error flag.
- `branch`, `target` and `halt` are ignored outside RUN.
- `retired` increments by 1 on every RUN cycle, including the HALT instruction's cycle.
- `retired` saturates at 2^CNT_W-1 and does not wrap.
- Reset values (asynchronous, immediate on reset low): state=IDLE, pc=0, retired=0, running=0, done=0.

## Timing
- Every output is a registered value or a decode of registered state; there is no combinational path from inputs to outputs.
- Branch latency: `branch`/`target` valid in cycle N redirects `pc` in cycle N+1. There is no delay slot and no flush.
- Start latency:
  - `start` high in cycle N gives `running`=1 and pc=start_addr in cycle N+1.
  - The first instruction retires in cycle N+1.
- Halt latency:
  - `halt` high in cycle N gives `running`=0 and `done`=1 in cycle N+1.
  - `retired` already includes the HALT instruction in cycle N+1.
- Simultaneous events:
  - halt+branch in the same cycle: halt wins; pc holds.
  - start+halt in HALTED: start is processed; halt is ignored.
- Reset asserted mid-RUN returns all state to reset values at once.
- After reset deasserts, the block stays in IDLE until a fresh `start`.

## Structure
- Shared package `cpu_pkg` holds:
  - `localparam PC_W = 10`.
  - `typedef enum logic [1:0] {PC_IDLE, PC_RUN, PC_HALTED} pc_state_e`.
  - the branch-target alignment constant `BR_ALIGN = 3`, used by the branch unit when forming targets.
- One sub-module is natural: `sat_counter`, a parameterised width counter with clear, enable and saturate, instantiated for `retired`.
- Next-pc mux and FSM stay inline.

## Test plan
- **Reset mid-run:** pulse reset low for 1 cycle after 5 retired instructions -> same cycle pc=0, retired=0, running=0, done=0. pc stays 0 with no retirement until `start`.
- **Sequential fetch:** start with start_addr=10'h010, then 4 cycles idle -> pc = 010,011,012,013,014; retired=4 after the 4th retirement.
- **Taken branch:** in RUN at pc=10'h020, assert branch with target=10'h0A8 -> next cycle pc=0A8, following cycle pc=0A9.
- **Halt priority:** at pc=10'h030, assert halt and branch with target=10'h100 together -> next cycle pc=030, running=0, done=1; further start-free cycles keep pc=030.
- **Wrap and restart:** start_addr=10'h3FE with 3 run cycles -> pc = 3FE,3FF,000. Then halt, then start with start_addr=10'h008 -> pc=008, retired=0, done=0.
- **Saturation and ignored start:** with CNT_W=4, run 20 cycles -> retired sticks at 15. A start pulse during RUN does not change pc or the count.
